mem_arbiter: RTL and testbench

Shares the single CPU memory port between the control unit's fetch/execute path (requester 0) and the program loader/debug port (requester 1). Sits between the requesters and the memory. Per transfer it:
- arbitrates round-robin,
- drives one memory access,
- waits out the fixed memory latency,
- returns read data with a one-cycle done pulse.

The control unit stalls its fetch/execute sequencing on `o_r0_done`.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/mem_arbiter_rr_pick2.sv | 23 ++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: arbiter state encoding, requester indices
// and the width of the memory-latency wait counter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// A single request always wins; on a tie the requester not served last wins.
module rr_pick2
  import cpu_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic valid_o,
  output logic idx_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    idx_o   = REQ_CPU;
    if (req0_i && req1_i) begin
      idx_o = (last_i == REQ_CPU) ? REQ_LDR : REQ_CPU;
    end else if (req1_i) begin
      idx_o = REQ_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the CPU
// fetch/execute path (requester 0) and the loader/debug port (requester 1).
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int MEM_LAT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_r0_req,
  input  logic            i_r1_req,
  input  logic            i_r0_we,
  input  logic            i_r1_we,
  input  logic [BITS-1:0] i_r0_addr,
  input  logic [BITS-1:0] i_r1_addr,
  input  logic [BITS-1:0] i_r0_wdata,
  input  logic [BITS-1:0] i_r1_wdata,
  output logic            o_r0_gnt,
  output logic            o_r1_gnt,
  output logic            o_r0_done,
  output logic            o_r1_done,
  output logic [BITS-1:0] o_r0_rdata,
  output logic [BITS-1:0] o_r1_rdata,
  output logic            o_mem_en,
  output logic            o_mem_we,
  output logic [BITS-1:0] o_mem_addr,
  output logic [BITS-1:0] o_mem_wdata,
  input  logic [BITS-1:0] i_mem_rdata,
  output logic            o_busy
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             we_q, we_d;
  logic [BITS-1:0]  addr_q, addr_d;
  logic [BITS-1:0]  wdata_q, wdata_d;
  logic             lastServed_q, lastServed_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             memEn_q, memEn_d, memWe_q, memWe_d;
  logic [BITS-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic             busy_q, busy_d;

  logic pickValid;
  logic pickIdx;

  rr_pick2 u_pick (
    .req0_i  (i_r0_req),
    .req1_i  (i_r1_req),
    .last_i  (lastServed_q),
    .valid_o (pickValid),
    .idx_o   (pickIdx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= REQ_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lastServed_q <= REQ_LDR;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      memEn_q      <= 1'b0;
      memWe_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lastServed_q <= lastServed_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      memEn_q      <= memEn_d;
      memWe_q      <= memWe_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  // Every output is a register, so pulses are set up one state ahead:
  // gnt/en are loaded on the IDLE->ISSUE edge, done on the CAPTURE->IDLE edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lastServed_d = lastServed_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    memEn_d      = 1'b0;
    memWe_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pickValid) begin
          sel_d   = pickIdx;
          we_d    = (pickIdx == REQ_LDR) ? i_r1_we    : i_r0_we;
          addr_d  = (pickIdx == REQ_LDR) ? i_r1_addr  : i_r0_addr;
          wdata_d = (pickIdx == REQ_LDR) ? i_r1_wdata : i_r0_wdata;
          memEn_d = 1'b1;
          memWe_d = we_d;
          gnt0_d  = (pickIdx == REQ_CPU);
          gnt1_d  = (pickIdx == REQ_LDR);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = (MEM_LAT > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!we_q) begin
          if (sel_q == REQ_LDR) rdata1_d = i_mem_rdata;
          else                  rdata0_d = i_mem_rdata;
        end
        done0_d      = (sel_q == REQ_CPU);
        done1_d      = (sel_q == REQ_LDR);
        lastServed_d = sel_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign o_r0_gnt    = gnt0_q;
  assign o_r1_gnt    = gnt1_q;
  assign o_r0_done   = done0_q;
  assign o_r1_done   = done1_q;
  assign o_r0_rdata  = rdata0_q;
  assign o_r1_rdata  = rdata1_q;
  assign o_mem_en    = memEn_q;
  assign o_mem_we    = memWe_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants and
// completions, a negedge monitor pops and compares them as the DUT pulses.
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam int P   = LAT + 2;

  logic       clk;
  logic       i_rst;
  logic       i_r0_req, i_r1_req, i_r0_we, i_r1_we;
  logic [7:0] i_r0_addr, i_r1_addr, i_r0_wdata, i_r1_wdata;
  logic       o_r0_gnt, o_r1_gnt, o_r0_done, o_r1_done;
  logic [7:0] o_r0_rdata, o_r1_rdata;
  logic       o_mem_en, o_mem_we;
  logic [7:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic       o_busy;

  typedef struct {
    int         cyc;
    logic       idx;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } xfer_t;

  xfer_t gntQ[$];
  xfer_t doneQ[$];
  xfer_t mg, md;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] pipe [LAT];

  mem_arbiter #(.BITS(8), .MEM_LAT(LAT)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_r0_req    (i_r0_req),
    .i_r1_req    (i_r1_req),
    .i_r0_we     (i_r0_we),
    .i_r1_we     (i_r1_we),
    .i_r0_addr   (i_r0_addr),
    .i_r1_addr   (i_r1_addr),
    .i_r0_wdata  (i_r0_wdata),
    .i_r1_wdata  (i_r1_wdata),
    .o_r0_gnt    (o_r0_gnt),
    .o_r1_gnt    (o_r1_gnt),
    .o_r0_done   (o_r0_done),
    .o_r1_done   (o_r1_done),
    .o_r0_rdata  (o_r0_rdata),
    .o_r1_rdata  (o_r1_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory with a LAT-deep read pipeline; 0xEE fills slots with no read behind them.
  assign i_mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= (o_mem_en === 1'b1 && o_mem_we === 1'b0) ? mem[o_mem_addr] : 8'hEE;
    if (i_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'h3C;
      mem[8'h11] <= 8'h5A;
    end else if (o_mem_en === 1'b1 && o_mem_we === 1'b1) begin
      mem[o_mem_addr] <= o_mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic gotoCycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetState();
    checkOutput("rstGnt0", o_r0_gnt, 0);
    checkOutput("rstGnt1", o_r1_gnt, 0);
    checkOutput("rstDone0", o_r0_done, 0);
    checkOutput("rstDone1", o_r1_done, 0);
    checkOutput("rstMemEn", o_mem_en, 0);
    checkOutput("rstMemWe", o_mem_we, 0);
    checkOutput("rstBusy", o_busy, 0);
    checkOutput("rstMemAddr", o_mem_addr, 0);
    checkOutput("rstMemWdata", o_mem_wdata, 0);
    checkOutput("rstRdata0", o_r0_rdata, 0);
    checkOutput("rstRdata1", o_r1_rdata, 0);
  endtask

  task automatic pushXfer(input logic idx, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rdataExp,
                          input int gntCyc, input bit expectDone);
    xfer_t e;
    e.cyc = gntCyc; e.idx = idx; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdataExp;
    gntQ.push_back(e);
    if (expectDone) begin
      e.cyc = gntCyc + LAT + 1;
      doneQ.push_back(e);
    end
  endtask

  // One-cycle request pulse from an idle arbiter at cycle 'start'.
  task automatic applyStimulus(input logic idx, input logic we, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic [7:0] rdataExp,
                               input int start, input bit expectDone);
    gotoCycle(start);
    if (idx) begin
      i_r1_req = 1'b1; i_r1_we = we; i_r1_addr = addr; i_r1_wdata = wdata;
    end else begin
      i_r0_req = 1'b1; i_r0_we = we; i_r0_addr = addr; i_r0_wdata = wdata;
    end
    pushXfer(idx, we, addr, wdata, rdataExp, start + 1, expectDone);
    gotoCycle(start + 1);
    i_r0_req = 1'b0;
    i_r1_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      checkOutput("memEnIsGnt", o_mem_en, o_r0_gnt | o_r1_gnt);
      if (o_mem_en !== 1'b1) checkOutput("memWeIdle", o_mem_we, 0);
    end
    if (o_r0_gnt === 1'b1 || o_r1_gnt === 1'b1) begin
      checkOutput("singleGnt", o_r0_gnt & o_r1_gnt, 0);
      if (gntQ.size() == 0) begin
        checkOutput("unexpectedGnt", 1, 0);
      end else begin
        mg = gntQ.pop_front();
        checkOutput("gntCycle", cyc, mg.cyc);
        checkOutput("gntIdx", o_r1_gnt, mg.idx);
        checkOutput("gntMemEn", o_mem_en, 1);
        checkOutput("gntMemWe", o_mem_we, mg.we);
        checkOutput("gntMemAddr", o_mem_addr, mg.addr);
        checkOutput("gntMemWdata", o_mem_wdata, mg.wdata);
      end
    end
    if (o_r0_done === 1'b1 || o_r1_done === 1'b1) begin
      checkOutput("singleDone", o_r0_done & o_r1_done, 0);
      if (doneQ.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        md = doneQ.pop_front();
        checkOutput("doneCycle", cyc, md.cyc);
        checkOutput("doneIdx", o_r1_done, md.idx);
        checkOutput("doneRdata", o_r1_done ? o_r1_rdata : o_r0_rdata, md.rdata);
        checkOutput("doneIdleBusy", o_busy, 0);
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_r0_req = 1'b1; i_r0_we = 1'b0; i_r0_addr = 8'h10; i_r0_wdata = 8'h11;
    i_r1_req = 1'b1; i_r1_we = 1'b0; i_r1_addr = 8'h11; i_r1_wdata = 8'h22;

    // Reset held two edges with both requests up: nothing may be granted.
    gotoCycle(1);
    @(negedge clk);
    checkResetState();
    gotoCycle(2);
    i_rst = 1'b0;
    @(negedge clk);
    checkResetState();

    // Both requests held from t=2: alternating 0,1,0,1 every P cycles, r0 first.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) pushXfer(1'b0, 1'b0, 8'h10, 8'h11, 8'h3C, 3 + i * P, 1'b1);
      else            pushXfer(1'b1, 1'b0, 8'h11, 8'h22, 8'h5A, 3 + i * P, 1'b1);
    end
    gotoCycle(3 + 7 * P);
    i_r0_req = 1'b0;
    i_r1_req = 1'b0;

    // CPU read, loader write (r1 rdata keeps 0x5A), then readbacks of the write.
    applyStimulus(1'b0, 1'b0, 8'h10, 8'h00, 8'h3C, 40, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h20, 8'hA5, 8'h5A, 50, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 8'hA5, 60, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h20, 8'h00, 8'hA5, 70, 1'b1);

    // Reset while the read sits in WAIT: abandoned, no done, rdata cleared.
    applyStimulus(1'b0, 1'b0, 8'h11, 8'h00, 8'h00, 80, 1'b0);
    gotoCycle(82);
    i_rst = 1'b1;
    gotoCycle(83);
    i_rst = 1'b0;
    @(negedge clk);
    checkResetState();

    gotoCycle(100);
    checkOutput("gntQEmpty", gntQ.size(), 0);
    checkOutput("doneQEmpty", doneQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
